// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters feeding a 1-cycle
// coordinate stage for the pattern source and a 3-cycle sync/blank/RGB stage.
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oRequest,
  output logic       oFrame_Start,
  output logic [7:0] oFrame_Cnt,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BACK + H_ACT);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BACK + V_ACT);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       active_d, hsync_d, vsync_d, frame_start_d;
  logic [9:0] x_d, y_d;

  // Stage 1 (coordinates) and in-sync flags carried down the pipe
  logic [9:0] x_q, y_q;
  logic       req_q, frame_start_q, hs1_q, vs1_q;
  logic [7:0] frame_cnt_q;
  // Stage 2
  logic       act2_q, hs2_q, vs2_q;
  // Stage 3 (pins)
  logic       hs_n_q, vs_n_q, blank_n_q;
  logic [9:0] r_q, g_q, b_q;

  always_comb begin
    h_d = (h_q == H_MAX) ? 10'd0 : h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_MAX) begin
      v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
    end
    active_d      = (h_q >= H_ACT_LO) && (h_q < H_ACT_HI) &&
                    (v_q >= V_ACT_LO) && (v_q < V_ACT_HI);
    x_d           = active_d ? h_q - H_ACT_LO : 10'd0;
    y_d           = active_d ? v_q - V_ACT_LO : 10'd0;
    hsync_d       = h_q < H_SYNC_W;
    vsync_d       = v_q < V_SYNC_W;
    frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
  end

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      req_q         <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      act2_q        <= 1'b0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      hs_n_q        <= 1'b1;
      vs_n_q        <= 1'b1;
      blank_n_q     <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      req_q         <= active_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_q + {7'd0, frame_start_d};
      hs1_q         <= hsync_d;
      vs1_q         <= vsync_d;
      act2_q        <= req_q;
      hs2_q         <= hs1_q;
      vs2_q         <= vs1_q;
      hs_n_q        <= ~hs2_q;
      vs_n_q        <= ~vs2_q;
      blank_n_q     <= act2_q;
      // Pattern stage returns colour one cycle after the coordinate, i.e. now
      r_q           <= act2_q ? iRed   : 10'd0;
      g_q           <= act2_q ? iGreen : 10'd0;
      b_q           <= act2_q ? iBlue  : 10'd0;
    end
  end

  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oRequest     = req_q;
  assign oFrame_Start = frame_start_q;
  assign oFrame_Cnt   = frame_cnt_q;
  assign oVGA_HS      = hs_n_q;
  assign oVGA_VS      = vs_n_q;
  assign oVGA_BLANK_N = blank_n_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small-raster instance checked cycle by cycle
// through expected-value queues, plus a default-raster instance for 640x480 landmarks.
module tb_vga_timing_gen;

  localparam int SH = 4, BH = 3, AH = 8, FH = 2;   // H_TOTAL 17, active h 7..14
  localparam int SV = 2, BV = 2, AV = 4, FV = 1;   // V_TOTAL 9,  active v 4..7
  localparam int HT = SH + BH + AH + FH;
  localparam int VT = SV + BV + AV + FV;
  localparam int FRAME = HT * VT;                  // 153

  typedef struct packed {
    logic       req;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] cnt;
  } s1_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } s3_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_d;
  logic [9:0] red, grn, blu;
  logic [9:0] zero10;
  logic [9:0] x, y, r, g, b;
  logic       req, fs, hs, vs, blank;
  logic [7:0] cnt;
  logic [9:0] x_d, y_d, r_d, g_d, b_d;
  logic       req_d, fs_d, hs_d, vs_d, blank_d;
  logic [7:0] cnt_d;

  int tests = 0;
  int fails = 0;

  vga_timing_gen #(
    .H_SYNC(SH), .H_BACK(BH), .H_ACT(AH), .H_FRONT(FH),
    .V_SYNC(SV), .V_BACK(BV), .V_ACT(AV), .V_FRONT(FV)
  ) dut (
    .iVGA_CLK(clk), .iRST(rst),
    .iRed(red), .iGreen(grn), .iBlue(blu),
    .oVGA_X(x), .oVGA_Y(y), .oRequest(req), .oFrame_Start(fs), .oFrame_Cnt(cnt),
    .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(blank),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b)
  );

  vga_timing_gen dut_def (
    .iVGA_CLK(clk), .iRST(rst_d),
    .iRed(zero10), .iGreen(zero10), .iBlue(zero10),
    .oVGA_X(x_d), .oVGA_Y(y_d), .oRequest(req_d), .oFrame_Start(fs_d), .oFrame_Cnt(cnt_d),
    .oVGA_HS(hs_d), .oVGA_VS(vs_d), .oVGA_BLANK_N(blank_d),
    .oVGA_R(r_d), .oVGA_G(g_d), .oVGA_B(b_d)
  );

  assign zero10 = 10'd0;

  // Downstream pattern stage: registered colour from the coordinates
  always @(posedge clk) begin
    red <= x;
    grn <= 10'd1023;
    blu <= y;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_act(input int h, input int v);
    return (h >= SH + BH) && (h < SH + BH + AH) && (v >= SV + BV) && (v < SV + BV + AV);
  endfunction

  function automatic logic [62:0] pins_small();
    return {x, y, req, fs, cnt, hs, vs, blank, r, g, b};
  endfunction

  localparam logic [62:0] RST_PINS = {10'd0, 10'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 30'd0};

  s1_t q1[$];
  s3_t q3[$];
  int  hm, vm, fc;
  int  fs_seen, ncyc, last_fs;

  // Default-raster landmark statistics
  int  ed, hs_low, vs_low, fall1, fall2;
  int  req_first, run_len, x_bad;
  int  x_first, y_first, x_after, req_after;
  logic hs_prev, run_done;

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    hm = 0; vm = 0; fc = 0;
    fs_seen = 0; ncyc = 0; last_fs = 0;
    ed = 0; hs_low = 0; vs_low = 0; fall1 = 0; fall2 = 0;
    req_first = 0; run_len = 0; x_bad = 0; x_first = 0; y_first = 0;
    x_after = 0; req_after = 1;
    hs_prev = 1'b1; run_done = 1'b0;

    fork
      // Model: per edge, push what the pins must show after it
      begin : model
        logic primed;
        s1_t  e1;
        s3_t  e3;
        s3_t  r3;
        primed = 1'b0;
        r3 = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, r: 10'd0, g: 10'd0, b: 10'd0};
        forever begin
          @(posedge clk);
          if (rst) begin
            hm = 0; vm = 0; fc = 0;
            q1.delete(); q3.delete();
            primed = 1'b0;
          end else begin
            if (!primed) begin
              q3.push_back(r3);
              q3.push_back(r3);
              primed = 1'b1;
            end
            if (hm == 0 && vm == 0) fc = (fc + 1) % 256;
            e1.req = is_act(hm, vm);
            e1.fs  = (hm == 0 && vm == 0);
            e1.x   = e1.req ? 10'(hm - (SH + BH)) : 10'd0;
            e1.y   = e1.req ? 10'(vm - (SV + BV)) : 10'd0;
            e1.cnt = 8'(fc);
            q1.push_back(e1);
            e3.hs    = !(hm < SH);
            e3.vs    = !(vm < SV);
            e3.blank = e1.req;
            e3.r     = e1.x;
            e3.g     = e1.req ? 10'd1023 : 10'd0;
            e3.b     = e1.y;
            q3.push_back(e3);
            hm = hm + 1;
            if (hm == HT) begin
              hm = 0;
              vm = (vm + 1) % VT;
            end
          end
        end
      end

      // Monitor: pop and compare every cycle the small instance runs
      begin : monitor
        s1_t g1;
        s3_t g3;
        forever begin
          @(negedge clk);
          if (rst) begin
            fs_seen = 0; ncyc = 0; last_fs = 0;
          end else begin
            ncyc++;
            if (q1.size() == 0) check("stage1_queue_empty", 64'd0, 64'd1);
            else begin
              g1 = q1.pop_front();
              check("stage1", 64'({req, fs, x, y, cnt}), 64'(g1));
            end
            if (q3.size() == 0) check("stage3_queue_empty", 64'd0, 64'd1);
            else begin
              g3 = q3.pop_front();
              check("stage3", 64'({hs, vs, blank, r, g, b}), 64'(g3));
            end
            if (fs) begin
              if (fs_seen > 0) check("frame_period", 64'(ncyc - last_fs), 64'(FRAME));
              last_fs = ncyc;
              fs_seen++;
            end
          end
        end
      end

      begin : def_stats
        forever begin
          @(negedge clk);
          if (!rst_d) begin
            ed++;
            if (!hs_d && ed <= 802) hs_low++;
            if (hs_prev && !hs_d) begin
              if (fall1 == 0) fall1 = ed;
              else if (fall2 == 0) fall2 = ed;
            end
            hs_prev = hs_d;
            if (!vs_d && ed <= 30000) vs_low++;
            if (req_d && !run_done) begin
              if (req_first == 0) begin
                req_first = ed; x_first = int'(x_d); y_first = int'(y_d);
              end
              if (int'(x_d) != run_len) x_bad++;
              run_len++;
            end else if (req_first != 0 && !run_done) begin
              run_done = 1'b1;
              x_after = int'(x_d);
              req_after = int'(req_d);
            end
          end
        end
      end
    join_none

    // Reset values held while in reset, across clock edges
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins", 64'(pins_small()), 64'(RST_PINS));
    check("reset_default_sync", 64'({hs_d, vs_d, blank_d, fs_d}), 64'({1'b1, 1'b1, 1'b0, 1'b0}));

    @(negedge clk); #1;
    rst = 1'b0; rst_d = 1'b0;

    for (int i = 0; i < 4 * FRAME && fs_seen < 2; i++) @(negedge clk);
    check("two_frames_seen", 64'(fs_seen >= 2), 64'd1);

    // Mid-frame reset at h=10, v=5 (inside the active area)
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (hm == 10 && vm == 5) break;
    end
    check("midframe_position", 64'({hm[9:0], vm[9:0]}), 64'({10'd10, 10'd5}));
    #1 rst = 1'b1;
    #1;
    check("midframe_reset_pins", 64'(pins_small()), 64'(RST_PINS));
    repeat (2) @(posedge clk);
    #1;
    check("midframe_reset_held", 64'(pins_small()), 64'(RST_PINS));
    @(negedge clk); #1;
    rst = 1'b0;

    // Run 256 frames from the restart; counter must be back at zero
    for (int i = 0; i < 256 * FRAME + 500 && fs_seen < 256; i++) begin
      @(negedge clk); #2;
    end
    check("frames_after_restart", 64'(fs_seen), 64'd256);
    check("frame_cnt_wrap", 64'(cnt), 64'd0);

    for (int i = 0; i < 31000 && ed < 30000; i++) @(negedge clk);
    check("default_hs_first_low_edge", 64'(fall1), 64'd3);
    check("default_hs_low_cycles", 64'(hs_low), 64'd96);
    check("default_hs_next_low_edge", 64'(fall2), 64'd803);
    check("default_vs_low_cycles", 64'(vs_low), 64'd1600);
    check("default_first_request_edge", 64'(req_first), 64'd28145);
    check("default_first_xy", 64'({x_first[9:0], y_first[9:0]}), 64'd0);
    check("default_line_request_run", 64'(run_len), 64'd640);
    check("default_x_sequence_errors", 64'(x_bad), 64'd0);
    check("default_after_line", 64'({x_after[9:0], req_after[0]}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: horizontal sync width in pixel clocks.
REQ-002 SHALL have parameter H_BACK, default 48: horizontal back porch.
REQ-003 SHALL have parameter H_ACT, default 640: active pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 16: horizontal front porch.
REQ-005 SHALL have parameter V_SYNC, default 2: vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, default 33: vertical back porch.
REQ-007 SHALL have parameter V_ACT, default 480: active lines.
REQ-008 SHALL have parameter V_FRONT, default 10: vertical front porch.
REQ-009 SHALL have ports (clock and reset first):
- iVGA_CLK  in  1  pixel clock; single clock domain, all logic on rising edge
- iRST  in  1  reset, asynchronous, active-high
- iRed / iGreen / iBlue  in  10 each  pixel colour from downstream pattern stage, registered there, valid 1 cycle after oVGA_X/oVGA_Y
- oVGA_X  out  10  active-area column coordinate to pattern stage
- oVGA_Y  out  10  active-area row coordinate to pattern stage
- oRequest  out  1  high when oVGA_X/oVGA_Y name an active pixel
- oFrame_Start  out  1  one-cycle pulse at start of each frame
- oFrame_Cnt  out  8  frame counter
- oVGA_HS / oVGA_VS  out  1 each  sync to DAC, active-low
- oVGA_BLANK_N  out  1  high during active video
- oVGA_R / oVGA_G / oVGA_B  out  10 each  pixel to DAC

Function
REQ-010 SHALL keep H counter h over 0..H_TOTAL-1 (H_TOTAL = sum of H params, 800 default), increment every cycle, wrap to 0.
REQ-011 SHALL keep V counter v over 0..V_TOTAL-1 (525 default), increment only when h wraps; v wraps to 0 when h and v both at max.
REQ-012 SHALL order regions: sync, back porch, active, front porch; active when H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_ACT and likewise for v (default h 144..783, v 35..514).
REQ-013 Stage 1 (1 cycle after counter state (h,v)): SHALL register oRequest = active(h,v); oVGA_X = h-144, oVGA_Y = v-35 when active, else both 0.
REQ-014 Stage 1: SHALL register oFrame_Start = 1 exactly when (h,v) = (0,0).
REQ-015 SHALL increment oFrame_Cnt by 1 in the cycle oFrame_Start is registered high; SHALL wrap 255 -> 0.
REQ-016 Stage 3 (3 cycles after (h,v)): SHALL register oVGA_HS = 0 iff h < H_SYNC, oVGA_VS = 0 iff v < V_SYNC, oVGA_BLANK_N = active(h,v).
REQ-017 Stage 3: SHALL register oVGA_R/G/B = iRed/iGreen/iBlue when delayed active flag is 1, else 0; colour and sync at pins for one pixel SHALL be cycle-aligned.
REQ-018 Counter-to-pin latency SHALL be exactly 3 cycles for sync/blank/RGB; counter-to-coordinate latency exactly 1.
REQ-019 All arithmetic SHALL be unsigned, 10-bit counters; no outputs combinational from inputs.

Reset
REQ-020 While iRST = 1: h = v = 0, pipeline flags cleared, oVGA_X = oVGA_Y = 0, oRequest = oFrame_Start = 0, oFrame_Cnt = 0, oVGA_HS = oVGA_VS = 1, oVGA_BLANK_N = 0, RGB = 0, taking effect immediately without a clock.
REQ-021 First rising edge with iRST = 0 SHALL advance h 0 -> 1 and register stage-1 outputs for (0,0); after edge n, stage 1 reflects counter value n-1.
REQ-022 Reset asserted mid-frame SHALL abandon the frame; timing restarts from (0,0) with no partial pulse on oFrame_Start.

Verification
REQ-023 Reset release, free run: oFrame_Start high after edge 1; oVGA_HS low for edges 3..98 exactly (96 cycles), next low at edge 803; oVGA_VS low for 1600 cycles per frame.
REQ-024 First active pixel: oRequest first high after edge 28145 with oVGA_X = 0, oVGA_Y = 0; line holds 640 consecutive request cycles, X 0..639, then X = 0, request low.
REQ-025 Loopback model: bench pattern registers iRed = iGreen = iBlue = 1023 -> oVGA_R/G/B = 1023 exactly when oVGA_BLANK_N = 1, else 0; 307200 such cycles per frame.
REQ-026 Frame period: oFrame_Start pulses every 420000 cycles; after 256 frames oFrame_Cnt reads 0 again.
REQ-027 Bench pattern iRed = delayed oVGA_X: at each oVGA_BLANK_N rising edge oVGA_R = 0; last active cycle of line oVGA_R = 639; last active line Y = 479.
REQ-028 iRST pulsed high when h = 500, v = 200 -> all outputs at reset values same cycle; after release sequence matches REQ-023 exactly.
